sid_write_ctrl: RTL and testbench

- Register-write scheduler for the mos6581 bus (sid_addr/sid_data/sid_n_cs), clocked by the slow control clock.
- Replays a fixed power-on init table, then forwards address/data byte pairs from a byte stream (UART receiver) through a small FIFO.
- Guarantees well-formed chip-select pulses and arbitrates init writes against stream writes.

---
 rtl/sid_write_ctrl.sv | 277 +++++++++++++++++++++++++++
 tb/tb_sid_write_ctrl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sid_write_ctrl.sv
`timescale 1ns / 1ps
// sid_write_ctrl
//   Register-write scheduler for the mos6581 (SID) bus, clocked by the slow
//   control clock. An optional power-on init table is replayed first. After
//   that, address/data byte pairs from a byte stream (UART receiver) are
//   buffered in a small FIFO and written to the chip. Every write is a single
//   active-low chip-select pulse of exactly one cycle. The scheduler adds at
//   least one high cycle between writes, so there is at most one write every
//   two cycles.
//
//   Build option: SID_INIT_EN
//     defined   - init table present; reset and init_start replay it.
//     undefined - no table; reset goes straight to RUN and init_start is
//                 ignored. Only stream writes reach the chip.
//
//   Parameters
//     FIFO_DEPTH  buffered addr/data pairs (power of 2, >= 2)
//
//   Ports
//     clk_1k      control clock
//     n_reset     synchronous active-low reset
//     rx_data     stream byte
//     rx_valid    rx_data valid
//     rx_ready    byte accepted on an edge with rx_valid && rx_ready (= !fifo_full)
//     init_start  one-cycle request to replay the init table
//     sid_addr    SID register address
//     sid_data    SID write data
//     sid_n_cs    SID chip select, active-low write strobe
//     busy        init in progress, FIFO non-empty, or strobe/gap active
//     wr_count    completed SID writes, wraps 255 -> 0
module sid_write_ctrl #(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic       clk_1k,
  input  logic       n_reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  input  logic       init_start,
  output logic [4:0] sid_addr,
  output logic [7:0] sid_data,
  output logic       sid_n_cs,
  output logic       busy,
  output logic [7:0] wr_count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StInit, StRun, StStrobe, StGap} sched_e;
  typedef enum logic {PsAddr, PsData} parse_e;

  // ---------------------------------------------------------------------------
  // Byte-stream parser and pair FIFO
  // ---------------------------------------------------------------------------
  parse_e          ps_q, ps_d;
  logic [4:0]      rx_addr_q, rx_addr_d;
  logic [12:0]     fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            fifo_full, fifo_empty;
  logic            rx_fire, push, pop;
  logic [12:0]     fifo_rdata;

  assign fifo_full  = (cnt_q == CntFull);
  assign fifo_empty = (cnt_q == '0);
  assign rx_ready   = !fifo_full;
  assign rx_fire    = rx_valid && rx_ready;
  assign fifo_rdata = fifo_mem[rd_ptr_q];

  always_comb begin
    ps_d      = ps_q;
    rx_addr_d = rx_addr_q;
    push      = 1'b0;
    unique case (ps_q)
      // Bytes above 0x1F cannot be addresses; dropping them resyncs the stream.
      PsAddr: begin
        if (rx_fire && (rx_data[7:5] == 3'b000)) begin
          rx_addr_d = rx_data[4:0];
          ps_d      = PsData;
        end
      end
      PsData: begin
        if (rx_fire) begin
          push = 1'b1;
          ps_d = PsAddr;
        end
      end
    endcase
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of 2.
  always_comb begin
    wr_ptr_d = push ? (wr_ptr_q + PtrOne) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PtrOne) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntOne;
      2'b01:   cnt_d = cnt_q - CntOne;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_1k) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {rx_addr_q, rx_data};
    end
  end

  // ---------------------------------------------------------------------------
  // Init table
  // ---------------------------------------------------------------------------
  logic init_req;

`ifdef SID_INIT_EN
  localparam logic [3:0] InitCount = 4'd11;

  logic [3:0]  init_idx_q, init_idx_d;
  logic        init_act_q, init_act_d;
  logic        init_pend_q, init_pend_d;
  logic [12:0] init_entry;

  // A request is only remembered while no init sequence is running.
  assign init_req = init_pend_q || (init_start && !init_act_q);

  always_comb begin
    unique case (init_idx_q)
      4'd0:    init_entry = {5'h18, 8'd8};
      4'd1:    init_entry = {5'h05, 8'd190};
      4'd2:    init_entry = {5'h06, 8'd248};
      4'd3:    init_entry = {5'h01, 8'd17};
      4'd4:    init_entry = {5'h00, 8'd37};
      4'd5:    init_entry = {5'h04, 8'd17};
      4'd6:    init_entry = {5'h13, 8'd190};
      4'd7:    init_entry = {5'h14, 8'd248};
      4'd8:    init_entry = {5'h0F, 8'd17};
      4'd9:    init_entry = {5'h0E, 8'd37};
      4'd10:   init_entry = {5'h12, 8'd33};
      default: init_entry = 13'h0000;
    endcase
  end
`else
  logic unused_init_start;

  assign unused_init_start = init_start;
  assign init_req          = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Write scheduler
  // ---------------------------------------------------------------------------
  sched_e      state_q, state_d;
  logic [4:0]  sid_addr_q, sid_addr_d;
  logic [7:0]  sid_data_q, sid_data_d;
  logic        sid_n_cs_q, sid_n_cs_d;
  logic [7:0]  wr_count_q, wr_count_d;
  logic        busy_q, busy_d;

  always_comb begin
    state_d    = state_q;
    sid_addr_d = sid_addr_q;
    sid_data_d = sid_data_q;
    sid_n_cs_d = 1'b1;
    wr_count_d = wr_count_q;
    pop        = 1'b0;
`ifdef SID_INIT_EN
    init_idx_d  = init_idx_q;
    init_act_d  = init_act_q;
    init_pend_d = init_req;
`endif

    unique case (state_q)
      StInit: begin
`ifdef SID_INIT_EN
        {sid_addr_d, sid_data_d} = init_entry;
        sid_n_cs_d = 1'b0;
        init_idx_d = init_idx_q + 4'd1;
        state_d    = StStrobe;
`else
        state_d = StRun;
`endif
      end
      StRun: begin
        // A pending init beats queued stream writes.
        if (init_req) begin
          state_d = StInit;
`ifdef SID_INIT_EN
          init_idx_d  = '0;
          init_act_d  = 1'b1;
          init_pend_d = 1'b0;
`endif
        end else if (!fifo_empty) begin
          pop        = 1'b1;
          {sid_addr_d, sid_data_d} = fifo_rdata;
          sid_n_cs_d = 1'b0;
          state_d    = StStrobe;
        end
      end
      StStrobe: begin
        wr_count_d = wr_count_q + 8'd1;
        state_d    = StGap;
      end
      StGap: begin
        state_d = StRun;
`ifdef SID_INIT_EN
        if (init_act_q) begin
          if (init_idx_q == InitCount) begin
            init_act_d = 1'b0;
          end else begin
            state_d = StInit;
          end
        end
`endif
      end
    endcase

    busy_d = (state_d != StRun) || (cnt_d != '0);
`ifdef SID_INIT_EN
    busy_d = busy_d || init_pend_d;
`endif
  end

  always_ff @(posedge clk_1k) begin
    if (!n_reset) begin
`ifdef SID_INIT_EN
      state_q <= StInit;
`else
      state_q <= StRun;
`endif
      ps_q       <= PsAddr;
      rx_addr_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      sid_addr_q <= '0;
      sid_data_q <= '0;
      sid_n_cs_q <= 1'b1;
      wr_count_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ps_q       <= ps_d;
      rx_addr_q  <= rx_addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      sid_addr_q <= sid_addr_d;
      sid_data_q <= sid_data_d;
      sid_n_cs_q <= sid_n_cs_d;
      wr_count_q <= wr_count_d;
      busy_q     <= busy_d;
    end
  end

`ifdef SID_INIT_EN
  always_ff @(posedge clk_1k) begin
    if (!n_reset) begin
      init_idx_q  <= '0;
      init_act_q  <= 1'b1;
      init_pend_q <= 1'b0;
    end else begin
      init_idx_q  <= init_idx_d;
      init_act_q  <= init_act_d;
      init_pend_q <= init_pend_d;
    end
  end
`endif

  assign sid_addr = sid_addr_q;
  assign sid_data = sid_data_q;
  assign sid_n_cs = sid_n_cs_q;
  assign busy     = busy_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_sid_write_ctrl.sv
`timescale 1ns / 1ps
// Directed bench for sid_write_ctrl. Works with SID_INIT_EN defined or not.
module tb_sid_write_ctrl;

  localparam int Depth = 8;
`ifdef SID_INIT_EN
  localparam int InitN = 11;
`else
  localparam int InitN = 0;
`endif

  logic       clk_1k = 1'b0;
  logic       n_reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       init_start;
  logic [4:0] sid_addr;
  logic [7:0] sid_data;
  logic       sid_n_cs;
  logic       busy;
  logic [7:0] wr_count;

  sid_write_ctrl #(
    .FIFO_DEPTH(Depth)
  ) dut (
    .clk_1k    (clk_1k),
    .n_reset   (n_reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .init_start(init_start),
    .sid_addr  (sid_addr),
    .sid_data  (sid_data),
    .sid_n_cs  (sid_n_cs),
    .busy      (busy),
    .wr_count  (wr_count)
  );

  always #5 clk_1k = ~clk_1k;

  int total = 0;
  int bad = 0;
  int exp_wr = 0;
  int cyc = 0;
  int acc_cyc = 0;
  bit saw_full = 0;

  // Write monitor: logs each strobe (addr/data and cycle) plus pulse widths.
  logic [12:0] wr_q[$];
  int          wr_cyc[$];
  int          low_run = 0;
  int          high_run = 0;
  int          max_low = 0;
  int          min_gap = 1000;
  bit          seen = 0;

  always @(posedge clk_1k) begin
    #1;
    cyc++;
    if (sid_n_cs === 1'b0) begin
      if (low_run == 0) begin
        wr_q.push_back({sid_addr, sid_data});
        wr_cyc.push_back(cyc);
        if (seen && high_run < min_gap) min_gap = high_run;
        seen = 1;
      end
      low_run++;
      if (low_run > max_low) max_low = low_run;
      high_run = 0;
    end else begin
      low_run = 0;
      high_run++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [12:0] init_entry(input int i);
    case (i)
      0:       return {5'h18, 8'd8};
      1:       return {5'h05, 8'd190};
      2:       return {5'h06, 8'd248};
      3:       return {5'h01, 8'd17};
      4:       return {5'h00, 8'd37};
      5:       return {5'h04, 8'd17};
      6:       return {5'h13, 8'd190};
      7:       return {5'h14, 8'd248};
      8:       return {5'h0F, 8'd17};
      9:       return {5'h0E, 8'd37};
      10:      return {5'h12, 8'd33};
      default: return 13'h0000;
    endcase
  endfunction

  task automatic clear_mon();
    wr_q.delete();
    wr_cyc.delete();
    max_low = 0;
    min_gap = 1000;
    seen    = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit done;
    done = 0;
    @(negedge clk_1k);
    rx_data  = b;
    rx_valid = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      #1;
      if (rx_ready === 1'b1) begin
        @(posedge clk_1k);
        #2;
        acc_cyc = cyc;
        done = 1;
      end else begin
        saw_full = 1;
        @(negedge clk_1k);
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL send_byte: byte %02h never accepted, rx_ready=%b required 1", b, rx_ready);
    end
  endtask

  task automatic send_pair(input logic [4:0] a, input logic [7:0] d);
    send_byte({3'b000, a});
    send_byte(d);
  endtask

  task automatic rx_idle();
    @(negedge clk_1k);
    rx_valid = 1'b0;
  endtask

  // Waits until n writes are logged and the block is idle, then settles.
  task automatic wait_done(input int n);
    bit ok;
    ok = 0;
    for (int k = 0; k < 600 && !ok; k++) begin
      @(posedge clk_1k);
      #3;
      if (wr_q.size() >= n && busy === 1'b0) ok = 1;
    end
    repeat (8) @(posedge clk_1k);
    #3;
  endtask

  task automatic test_reset();
    n_reset    = 1'b0;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
    init_start = 1'b0;
    repeat (3) @(posedge clk_1k);
    #1;
    total++; if (sid_n_cs !== 1'b1) begin bad++; $display("FAIL reset_ncs: got %b want 1", sid_n_cs); end
    total++; if (sid_addr !== 5'h00) begin bad++; $display("FAIL reset_addr: got %h want 00", sid_addr); end
    total++; if (sid_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", sid_data); end
    total++; if (wr_count !== 8'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", wr_count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", rx_ready); end
    @(negedge clk_1k);
    n_reset = 1'b1;
    clear_mon();
  endtask

  task automatic test_init();
    wait_done(InitN);
    total++;
    if (wr_q.size() != InitN) begin
      bad++; $display("FAIL init_count: got %0d writes want %0d", wr_q.size(), InitN);
    end
`ifdef SID_INIT_EN
    for (int i = 0; i < InitN; i++) begin
      total++;
      if (wr_q[i] !== init_entry(i)) begin
        bad++; $display("FAIL init_entry%0d: got %h want %h", i, wr_q[i], init_entry(i));
      end
    end
    total++; if (max_low != 1) begin bad++; $display("FAIL init_low_width: got %0d want 1", max_low); end
    total++;
    if (min_gap < 1 || min_gap > 2) begin
      bad++; $display("FAIL init_high_gap: got %0d want 1..2", min_gap);
    end
`endif
    exp_wr = InitN;
    total++; if (wr_count !== 8'(exp_wr)) begin bad++; $display("FAIL init_wr_count: got %0d want %0d", wr_count, exp_wr); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL init_busy: got %b want 0", busy); end
  endtask

  task automatic test_single();
    clear_mon();
    send_pair(5'h04, 8'h41);
    rx_idle();
    wait_done(1);
    exp_wr++;
    total++; if (wr_q.size() != 1) begin bad++; $display("FAIL single_count: got %0d want 1", wr_q.size()); end
    total++; if (wr_q[0] !== {5'h04, 8'h41}) begin bad++; $display("FAIL single_pair: got %h want %h", wr_q[0], {5'h04, 8'h41}); end
    total++;
    if (wr_cyc[0] - acc_cyc != 1) begin
      bad++; $display("FAIL single_latency: got %0d want 1", wr_cyc[0] - acc_cyc);
    end
    total++; if (max_low != 1) begin bad++; $display("FAIL single_low_width: got %0d want 1", max_low); end
    total++; if (wr_count !== 8'(exp_wr)) begin bad++; $display("FAIL single_wr_count: got %0d want %0d", wr_count, exp_wr); end
  endtask

  task automatic test_resync();
    clear_mon();
    send_byte(8'h20);
    send_byte(8'hFF);
    send_byte(8'h18);
    send_byte(8'h0F);
    rx_idle();
    wait_done(1);
    exp_wr++;
    total++; if (wr_q.size() != 1) begin bad++; $display("FAIL resync_count: got %0d want 1", wr_q.size()); end
    total++; if (wr_q[0] !== {5'h18, 8'h0F}) begin bad++; $display("FAIL resync_pair: got %h want %h", wr_q[0], {5'h18, 8'h0F}); end
    total++; if (wr_count !== 8'(exp_wr)) begin bad++; $display("FAIL resync_wr_count: got %0d want %0d", wr_count, exp_wr); end
  endtask

  task automatic test_back_to_back();
    logic [12:0] exp_q[$];
    int          npairs;
    clear_mon();
    saw_full = 0;
`ifdef SID_INIT_EN
    // Hold the scheduler in INIT so the FIFO fills.
    npairs = Depth + 1;
    for (int i = 0; i < 11; i++) exp_q.push_back(init_entry(i));
    @(negedge clk_1k);
    init_start = 1'b1;
    @(negedge clk_1k);
    init_start = 1'b0;
`else
    // Arrival (1 pair / 2 cycles) outpaces drain (1 write / 3 cycles).
    npairs = 4 * Depth;
`endif
    for (int i = 0; i < npairs; i++) begin
      logic [4:0] a;
      logic [7:0] d;
      a = 5'(i);
      d = 8'(8'h80 + i);
      send_pair(a, d);
      exp_q.push_back({a, d});
    end
    rx_idle();
    wait_done(exp_q.size());
    exp_wr += exp_q.size();
    total++; if (saw_full !== 1'b1) begin bad++; $display("FAIL b2b_ready_low: got %b want 1", saw_full); end
    total++;
    if (wr_q.size() != exp_q.size()) begin
      bad++; $display("FAIL b2b_count: got %0d want %0d", wr_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (wr_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL b2b_order%0d: got %h want %h", i, wr_q[i], exp_q[i]);
      end
    end
    total++; if (max_low != 1) begin bad++; $display("FAIL b2b_low_width: got %0d want 1", max_low); end
    total++; if (wr_count !== 8'(exp_wr)) begin bad++; $display("FAIL b2b_wr_count: got %0d want %0d", wr_count, exp_wr); end
  endtask

`ifdef SID_INIT_EN
  task automatic test_init_restart();
    logic [12:0] exp_q[$];
    bit          hit;
    clear_mon();
    hit = 0;
    for (int i = 0; i < 3; i++) exp_q.push_back({5'(5'h10 + i), 8'(8'h50 + i)});
    for (int i = 0; i < 11; i++) exp_q.push_back(init_entry(i));
    for (int i = 3; i < 5; i++) exp_q.push_back({5'(5'h10 + i), 8'(8'h50 + i)});
    fork
      begin
        for (int i = 0; i < 5; i++) send_pair(5'(5'h10 + i), 8'(8'h50 + i));
        rx_idle();
      end
      begin
        // Request init while the third stream write is strobing.
        for (int k = 0; k < 200 && !hit; k++) begin
          @(posedge clk_1k);
          #3;
          if (wr_q.size() >= 3) begin
            init_start = 1'b1;
            hit = 1;
          end
        end
        @(posedge clk_1k);
        #1;
        init_start = 1'b0;
      end
    join
    total++; if (hit !== 1'b1) begin bad++; $display("FAIL restart_trigger: got %b want 1", hit); end
    wait_done(exp_q.size());
    exp_wr += exp_q.size();
    total++;
    if (wr_q.size() != exp_q.size()) begin
      bad++; $display("FAIL restart_count: got %0d want %0d", wr_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (wr_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL restart_order%0d: got %h want %h", i, wr_q[i], exp_q[i]);
      end
    end
    total++; if (wr_count !== 8'(exp_wr)) begin bad++; $display("FAIL restart_wr_count: got %0d want %0d", wr_count, exp_wr); end
  endtask
`endif

  task automatic test_reset_strobe();
    bit hit;
    clear_mon();
    hit = 0;
    fork
      begin
        for (int i = 0; i < 3; i++) send_pair(5'(5'h08 + i), 8'(8'hC0 + i));
        rx_idle();
      end
      begin
        // Drop reset while the second write strobes; the third pair is queued.
        for (int k = 0; k < 200 && !hit; k++) begin
          @(posedge clk_1k);
          #3;
          if (wr_q.size() >= 2) begin
            n_reset = 1'b0;
            hit = 1;
          end
        end
      end
    join
    @(posedge clk_1k);
    #1;
    total++; if (hit !== 1'b1) begin bad++; $display("FAIL rststb_trigger: got %b want 1", hit); end
    total++; if (sid_n_cs !== 1'b1) begin bad++; $display("FAIL rststb_ncs: got %b want 1", sid_n_cs); end
    total++; if (wr_count !== 8'd0) begin bad++; $display("FAIL rststb_count: got %0d want 0", wr_count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rststb_busy: got %b want 0", busy); end
    total++; if (sid_addr !== 5'h00) begin bad++; $display("FAIL rststb_addr: got %h want 00", sid_addr); end
    @(negedge clk_1k);
    n_reset = 1'b1;
    clear_mon();
    wait_done(InitN);
    repeat (20) @(posedge clk_1k);
    #3;
    total++;
    if (wr_q.size() != InitN) begin
      bad++; $display("FAIL rststb_writes: got %0d want %0d", wr_q.size(), InitN);
    end
`ifdef SID_INIT_EN
    for (int i = 0; i < InitN; i++) begin
      total++;
      if (wr_q[i] !== init_entry(i)) begin
        bad++; $display("FAIL rststb_entry%0d: got %h want %h", i, wr_q[i], init_entry(i));
      end
    end
`endif
    total++; if (wr_count !== 8'(InitN)) begin bad++; $display("FAIL rststb_wr_count: got %0d want %0d", wr_count, InitN); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_single();
    test_resync();
    test_back_to_back();
`ifdef SID_INIT_EN
    test_init_restart();
`endif
    test_reset_strobe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
